// File: rtl/pattern_detector_param_if.sv
// Bus bundle for pattern_detector_param: symbol stream, configuration and results.
// PATDET_WILDCARD_EN adds the per-symbol cfg_mask signal.
interface pattern_detector_param_if #(
    parameter int SYM_W   = 4,
    parameter int SEQ_LEN = 4,
    parameter int CNT_W   = 8
);
    localparam int FILL_W = $clog2(SEQ_LEN + 1);

    logic [SYM_W-1:0]         in;
    logic                     valid;
    logic                     cfg_load;
    logic [SEQ_LEN*SYM_W-1:0] cfg_pattern;
`ifdef PATDET_WILDCARD_EN
    logic [SEQ_LEN-1:0]       cfg_mask;
`endif
    logic                     overlap;
    logic                     sequence_detected;
    logic [CNT_W-1:0]         match_count;
    logic [FILL_W-1:0]        fill_level;

`ifdef PATDET_WILDCARD_EN
    modport master (
        output in, valid, cfg_load, cfg_pattern, cfg_mask, overlap,
        input  sequence_detected, match_count, fill_level
    );
    modport slave (
        input  in, valid, cfg_load, cfg_pattern, cfg_mask, overlap,
        output sequence_detected, match_count, fill_level
    );
`else
    modport master (
        output in, valid, cfg_load, cfg_pattern, overlap,
        input  sequence_detected, match_count, fill_level
    );
    modport slave (
        input  in, valid, cfg_load, cfg_pattern, overlap,
        output sequence_detected, match_count, fill_level
    );
`endif
endinterface

// File: rtl/pattern_detector_param.sv
// Programmable SEQ_LEN-symbol sequence detector with overlap control and saturating match counter.
// Optional feature macro: PATDET_WILDCARD_EN (per-slot don't-care mask).
module pattern_detector_param #(
    parameter int SYM_W   = 4,
    parameter int SEQ_LEN = 4,
    parameter int CNT_W   = 8
) (
    input logic                     clk,
    input logic                     rst,
    pattern_detector_param_if.slave bus
);
    localparam int FILL_W = $clog2(SEQ_LEN + 1);

    typedef enum logic {S_FILL, S_ARMED} state_t;

    state_t                   r_state, w_state_next;
    logic [SYM_W-1:0]         r_hist [SEQ_LEN];
    logic [SYM_W-1:0]         w_hist_shift [SEQ_LEN];
    logic [SEQ_LEN*SYM_W-1:0] r_pattern;
`ifdef PATDET_WILDCARD_EN
    logic [SEQ_LEN-1:0]       r_mask;
`endif
    logic [FILL_W-1:0]        r_fill, w_fill_next, w_fill_inc;
    logic [CNT_W-1:0]         r_count;
    logic                     r_detect;
    logic                     w_accept, w_full, w_all_eq, w_match;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    function automatic logic [FILL_W-1:0] fill_inc(input logic [FILL_W-1:0] v);
        return (v == FILL_W'(SEQ_LEN)) ? v : v + 1'b1;
    endfunction

    // Slot 0 is the oldest symbol; the new symbol enters at the top slot.
    always_comb begin
        for (int k = 0; k < SEQ_LEN - 1; k++) begin
            w_hist_shift[k] = r_hist[k+1];
        end
        w_hist_shift[SEQ_LEN-1] = bus.in;
    end

    always_comb begin
        w_all_eq = 1'b1;
        for (int k = 0; k < SEQ_LEN; k++) begin
`ifdef PATDET_WILDCARD_EN
            w_all_eq = w_all_eq &
                       ((w_hist_shift[k] == r_pattern[k*SYM_W +: SYM_W]) | r_mask[k]);
`else
            w_all_eq = w_all_eq & (w_hist_shift[k] == r_pattern[k*SYM_W +: SYM_W]);
`endif
        end
    end

    // A symbol presented together with cfg_load is discarded.
    assign w_accept   = bus.valid & ~bus.cfg_load;
    assign w_fill_inc = fill_inc(r_fill);
    assign w_full     = (w_fill_inc == FILL_W'(SEQ_LEN));
    assign w_match    = w_accept & w_full & w_all_eq;

    always_comb begin
        w_state_next = r_state;
        w_fill_next  = r_fill;
        case (r_state)
            S_FILL: begin
                if (w_accept) begin
                    w_fill_next = w_fill_inc;
                    if (w_match && !bus.overlap) begin
                        w_fill_next = '0;
                    end else if (w_full) begin
                        w_state_next = S_ARMED;
                    end
                end
            end
            S_ARMED: begin
                if (w_accept) begin
                    w_fill_next = w_fill_inc;
                    if (w_match && !bus.overlap) begin
                        w_state_next = S_FILL;
                        w_fill_next  = '0;
                    end
                end
            end
            default: begin
                w_state_next = S_FILL;
                w_fill_next  = '0;
            end
        endcase
        if (bus.cfg_load) begin
            w_state_next = S_FILL;
            w_fill_next  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_FILL;
            r_fill    <= '0;
            r_detect  <= 1'b0;
            r_count   <= '0;
            r_pattern <= '0;
`ifdef PATDET_WILDCARD_EN
            r_mask    <= '0;
`endif
            for (int k = 0; k < SEQ_LEN; k++) r_hist[k] <= '0;
        end else begin
            r_state  <= w_state_next;
            r_fill   <= w_fill_next;
            r_detect <= w_match;
            if (w_match) r_count <= sat_inc(r_count);
            if (bus.cfg_load) begin
                r_pattern <= bus.cfg_pattern;
`ifdef PATDET_WILDCARD_EN
                r_mask    <= bus.cfg_mask;
`endif
                for (int k = 0; k < SEQ_LEN; k++) r_hist[k] <= '0;
            end else if (w_accept) begin
                for (int k = 0; k < SEQ_LEN; k++) r_hist[k] <= w_hist_shift[k];
            end
        end
    end

    assign bus.sequence_detected = r_detect;
    assign bus.match_count       = r_count;
    assign bus.fill_level        = r_fill;

endmodule

// File: doc/pattern_detector_param.md
# pattern_detector_param

Parametrised, programmable symbol-sequence detector for the FSM library. Watches a `valid`-qualified stream of `SYM_W`-bit symbols and pulses `sequence_detected` when the last `SEQ_LEN` accepted symbols equal a runtime-loaded pattern. Overlapping or non-overlapping matching is selected at run time, and a saturating match counter is provided. It supersedes the fixed 4-bit, fixed-pattern detector in system-level pattern checkers.

## Interface
Parameters:
- `SYM_W`, 4, symbol width in bits (≥1).
- `SEQ_LEN`, 4, pattern length in symbols (≥2).
- `CNT_W`, 8, width of the match counter.

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in`  in  SYM_W  input symbol.
- `valid`  in  1  `in` is accepted on a rising edge where `valid`=1.
- `cfg_load`  in  1  loads `cfg_pattern` (and `cfg_mask` if compiled in) and flushes history.
- `cfg_pattern`  in  SEQ_LEN*SYM_W  pattern; bits [SYM_W-1:0] are the FIRST symbol expected.
- `cfg_mask`  in  SEQ_LEN  per-symbol don't-care. Present only with `PATDET_WILDCARD_EN`.
- `overlap`  in  1  1 = overlapping matches, 0 = non-overlapping.
- `sequence_detected`  out  1  one-cycle match pulse.
- `match_count`  out  CNT_W  saturating count of matches.
- `fill_level`  out  $clog2(SEQ_LEN+1)  number of valid symbols held in history, 0..SEQ_LEN.

## Operation
- History: shift register of SEQ_LEN symbols. An accepted symbol enters at the newest slot, and the oldest is discarded.
- Fill counter: increments on each accepted symbol and saturates at SEQ_LEN. No match is possible until the fill reaches SEQ_LEN after including the current symbol.
- Match condition on an accepted beat: for every k, history_after_shift[k] == pattern[k]. Slot 0 is the oldest symbol. A slot whose mask bit is 1 always compares true (wildcard build only).
- State machine:
  - FILL: entered on reset or `cfg_load`. Stays here while fill < SEQ_LEN.
  - ARMED: entered when the fill reaches SEQ_LEN.
  - On a match with `overlap`=1: stays ARMED, and history is kept.
  - On a match with `overlap`=0: returns to FILL, with fill=0.
- `valid`=0: no shift, no state change, no detect. Gaps between symbols are transparent.
- `match_count` increments on every detect and saturates at 2^CNT_W-1 without wrapping.
- `cfg_load` has priority over `valid` in the same cycle. The pattern/mask are registered, the history is cleared, fill=0, the state goes to FILL, and the symbol presented that cycle is discarded. `match_count` is NOT cleared by `cfg_load`.
- `overlap` is sampled on each accepted beat. Changing it mid-stream takes effect at the next match.
- Pattern register reset value: all zeros, with mask all zeros.

## Timing
- Reset (`rst`=1 at an edge) sets: `sequence_detected`=0, `match_count`=0, `fill_level`=0, history=0, state=FILL.
- `rst` overrides `cfg_load` and `valid`.
- Reset asserted mid-sequence: the partial history is lost, and a match requires SEQ_LEN fresh symbols afterwards.
- Latency: the final matching symbol is sampled at edge N. `sequence_detected`=1 from edge N to edge N+1, and `match_count` updates at edge N.
- `sequence_detected` is registered and never high for two consecutive cycles unless two consecutive accepted beats both match (overlap mode, e.g. repeated-symbol patterns).
- `fill_level` reflects the registered fill after each edge.
- Back-to-back `valid` at full rate is supported. There is no backpressure.

## Configuration
- `PATDET_WILDCARD_EN` defined:
  - The `cfg_mask` port and mask register exist.
  - Masked slots match any symbol.
- `PATDET_WILDCARD_EN` undefined:
  - There is no `cfg_mask` port.
  - All slots require an exact compare.
- All other behaviour is identical between the two builds.

## Test plan
All scenarios use SYM_W=4, SEQ_LEN=3, CNT_W=4, and pattern A,B,C loaded via `cfg_load` with `cfg_pattern`=12'hCBA.
- Basic match: accept A,B,C with `overlap`=1 → `sequence_detected`=1 one cycle after C is sampled; `match_count`=1. Accepting A,B,D instead → no detect.
- Valid gaps and reset: accept A, then `valid`=0 for 5 cycles, then B,C → detect. Separately, assert `rst` between B and C, then accept C → no detect and `fill_level`=1.
- Overlap modes: load pattern A,A,A and feed A×5. `overlap`=1 → 3 detects, on symbols 3, 4 and 5. `overlap`=0 → 1 detect, on symbol 3.
- `cfg_load` collision: assert `cfg_load` with 12'h321 on the cycle C is presented → no detect, `fill_level`=0, and a subsequent 1,2,3 → detect.
- Saturation: produce 20 matches → `match_count` holds at 15.
- Wildcard (`PATDET_WILDCARD_EN` only): `cfg_mask`=3'b010 with pattern A,B,C → A,7,C detects, and A,F,C detects.
